mem_arbiter_fsm: RTL and testbench

//  Sequential arbiter sharing the single-ported RAM between instruction fetch (IF) and data access (MEM).

---
 rtl/mem_arbiter_fsm.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter_fsm.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_fsm.sv
// Arbiter sharing one single-ported RAM between instruction fetch and data access.
// Data has priority, a streak limit protects fetch, and a timeout forces an error completion.
module mem_arbiter_fsm #(
  parameter int          MAX_D_STREAK = 4,
  parameter int          TIMEOUT      = 255,
  parameter logic [31:0] ERR_WORD     = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  // instruction port
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  // data port
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  input  logic        halt,
  // RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } state_t;

  localparam logic [1:0] RS_ACCESS  = 2'd2;
  localparam logic [1:0] RS_ERROR   = 2'd3;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
  localparam logic [7:0] TCNT_LAST  = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [3:0]  dstreak, dstreak_nx;
  logic [7:0]  tcnt, tcnt_nx;
  logic        bus_err_nx;

  logic d_req, i_ok, d_win, i_win;
  logic granted, owner_req, done, fail, i_done, d_done, rearb;

  assign d_req = dREN | dWEN;
  assign i_ok  = iREN & ~halt;
  assign d_win = d_req & ~(i_ok & (dstreak == STREAK_MAX));
  assign i_win = ~d_win & i_ok;

  assign granted   = (state != IDLE) & ~RST;
  assign owner_req = (state == IGRANT) ? iREN : d_req;

  // Once the RAM reports ACCESS/ERROR (or the timeout fires) the access is
  // finished, so it is acknowledged even if the owner lets go this same cycle.
  assign done   = granted & ((ramstate == RS_ACCESS) | (ramstate == RS_ERROR) | (tcnt == TCNT_LAST));
  assign fail   = done & (ramstate != RS_ACCESS);
  assign i_done = done & (state == IGRANT);
  assign d_done = done & (state == DGRANT);

  // RAM strobes and port responses are decoded straight from the state.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (!RST) begin
      case (state)
        IGRANT: begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
        end
        DGRANT: begin
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    iwait = iREN & ~i_done;
    dwait = d_req & ~d_done;
    iload = i_done ? (fail ? ERR_WORD : ramload) : '0;
    dload = d_done ? (fail ? ERR_WORD : ramload) : '0;
  end

  // NOTE: every signal assigned in this always_comb gets a default first, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nx   = state;
    dstreak_nx = dstreak;
    tcnt_nx    = tcnt;
    bus_err_nx = bus_err;
    rearb      = 1'b0;

    case (state)
      IDLE: begin
        rearb   = 1'b1;
        tcnt_nx = '0;
      end
      IGRANT, DGRANT: begin
        if (done) begin
          rearb   = 1'b1;
          tcnt_nx = '0;
          if (fail) bus_err_nx = 1'b1;
        end else if (!owner_req) begin
          state_nx = IDLE;
          tcnt_nx  = '0;
        end else begin
          tcnt_nx = tcnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (rearb) begin
      if (d_win) begin
        state_nx = DGRANT;
        if (i_ok && dstreak != STREAK_MAX) dstreak_nx = dstreak + 4'd1;
      end else if (i_win) begin
        state_nx   = IGRANT;
        dstreak_nx = '0;
      end else begin
        state_nx = IDLE;
      end
    end

    // The streak only matters while fetch is actually waiting.
    if (!iREN) dstreak_nx = '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      dstreak <= '0;
      tcnt    <= '0;
      bus_err <= 1'b0;
    end else begin
      state   <= state_nx;
      dstreak <= dstreak_nx;
      tcnt    <= tcnt_nx;
      bus_err <= bus_err_nx;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_fsm.sv
// Directed bench for mem_arbiter_fsm: expected loads are queued when the RAM
// response is driven and popped when the owning port acknowledges.
module tb_mem_arbiter_fsm;

  localparam logic [1:0]  FREE   = 2'd0;
  localparam logic [1:0]  BUSY   = 2'd1;
  localparam logic [1:0]  ACCESS = 2'd2;
  localparam logic [1:0]  ERROR  = 2'd3;
  localparam logic [31:0] ERRW   = 32'hBAD1BAD1;
  localparam logic [31:0] S_IDLE = 32'd0;
  localparam logic [31:0] S_IGR  = 32'd1;
  localparam logic [31:0] S_DGR  = 32'd2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN, halt;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, bus_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] iq[$];
  logic [31:0] dq[$];

  always #5 CLK = ~CLK;

  mem_arbiter_fsm dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload), .halt(halt),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic ram(input logic [1:0] rs, input logic [31:0] ld);
    ramstate = rs;
    ramload  = ld;
  endtask

  // Scoreboard: an acknowledge while an expectation is queued consumes it.
  always @(negedge CLK) begin
    if (iq.size() > 0 && !iwait) chk("iload", iload, iq.pop_front());
    if (dq.size() > 0 && !dwait) chk("dload", dload, dq.pop_front());
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int early;
    RST = 1'b1; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b1; halt = 1'b0;
    iaddr = '0; daddr = '0; dstore = 32'h55; ram(FREE, 32'h0);

    // Reset: requests are visible but never acknowledged.
    smp();
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_dwait", 32'(dwait), 32'd1);
    chk("rst_ramwen", 32'(ramWEN), 32'd0);
    cyc(); RST = 1'b0; iREN = 1'b0; dWEN = 1'b0; dstore = '0;
    smp();
    chk("rst_state", 32'(dut.state), S_IDLE);
    chk("rst_ramren", 32'(ramREN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_dstreak", 32'(dut.dstreak), 32'd0);

    // Single fetch: BUSY, BUSY, ACCESS.
    cyc(); iREN = 1'b1; iaddr = 32'h40;
    smp(); chk("t1_c1_ramren", 32'(ramREN), 32'd0); chk("t1_c1_iwait", 32'(iwait), 32'd1);
    cyc(); ram(BUSY, 32'h0);
    smp(); chk("t1_c2_ramren", 32'(ramREN), 32'd1); chk("t1_c2_ramaddr", ramaddr, 32'h40);
    chk("t1_c2_iwait", 32'(iwait), 32'd1);
    cyc();
    smp(); chk("t1_c3_iwait", 32'(iwait), 32'd1); chk("t1_c3_ramren", 32'(ramREN), 32'd1);
    cyc(); ram(ACCESS, 32'h8C01); iq.push_back(32'h8C01); iREN = 1'b0;
    smp(); chk("t1_c4_ramren", 32'(ramREN), 32'd1);
    cyc(); ram(FREE, 32'h0);
    smp(); chk("t1_c5_ramren", 32'(ramREN), 32'd0); chk("t1_c5_state", 32'(dut.state), S_IDLE);

    // Fetch and write together: data first, fetch granted on the write's completion.
    cyc(); iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hAA;
    smp(); chk("t2_c1_ramwen", 32'(ramWEN), 32'd0);
    cyc(); ram(BUSY, 32'h0);
    smp();
    chk("t2_state_d", 32'(dut.state), S_DGR);
    chk("t2_ramwen", 32'(ramWEN), 32'd1);
    chk("t2_ramren", 32'(ramREN), 32'd0);
    chk("t2_ramaddr", ramaddr, 32'h100);
    chk("t2_ramstore", ramstore, 32'hAA);
    chk("t2_iwait", 32'(iwait), 32'd1);
    chk("t2_dstreak", 32'(dut.dstreak), 32'd1);
    cyc(); ram(ACCESS, 32'h0); dq.push_back(32'h0); dWEN = 1'b0;
    smp(); chk("t2_iwait_dcomp", 32'(iwait), 32'd1);
    cyc(); ram(BUSY, 32'h0);
    smp();
    chk("t2_state_i", 32'(dut.state), S_IGR);
    chk("t2_i_ramaddr", ramaddr, 32'h80);
    chk("t2_i_ramwen", 32'(ramWEN), 32'd0);
    chk("t2_dstreak0", 32'(dut.dstreak), 32'd0);
    cyc(); ram(ACCESS, 32'h1234); iq.push_back(32'h1234); iREN = 1'b0;
    smp();
    cyc(); ram(FREE, 32'h0);
    smp(); chk("t2_idle", 32'(dut.state), S_IDLE);

    // Fetch held against back-to-back reads: four data grants, then fetch.
    cyc(); iREN = 1'b1; iaddr = 32'h200; dREN = 1'b1; daddr = 32'h300;
    smp();
    for (int k = 1; k <= 4; k++) begin
      cyc(); ram(ACCESS, 32'hD000_0000 + 32'(k)); dq.push_back(32'hD000_0000 + 32'(k));
      smp();
      chk($sformatf("t3_state_d%0d", k), 32'(dut.state), S_DGR);
      chk($sformatf("t3_dstreak%0d", k), 32'(dut.dstreak), 32'(k));
      chk($sformatf("t3_iwait%0d", k), 32'(iwait), 32'd1);
    end
    cyc(); ram(ACCESS, 32'h5555); iq.push_back(32'h5555); iREN = 1'b0;
    smp();
    chk("t3_state_i", 32'(dut.state), S_IGR);
    chk("t3_dstreak0", 32'(dut.dstreak), 32'd0);
    chk("t3_ramaddr", ramaddr, 32'h200);
    chk("t3_dwait", 32'(dwait), 32'd1);
    cyc(); ram(ACCESS, 32'hD000_0005); dq.push_back(32'hD000_0005); dREN = 1'b0;
    smp(); chk("t3_state_d5", 32'(dut.state), S_DGR);
    cyc(); ram(FREE, 32'h0);
    smp(); chk("t3_idle", 32'(dut.state), S_IDLE);

    // Stuck RAM: timeout completes as an error on grant cycle 255.
    cyc(); dREN = 1'b1; daddr = 32'h400; ram(BUSY, 32'h0);
    smp();
    early = 0;
    for (int k = 1; k <= 254; k++) begin
      cyc(); smp();
      if (dwait !== 1'b1) early++;
    end
    chk("t4_no_early_ack", 32'(early), 32'd0);
    cyc(); dq.push_back(ERRW); dREN = 1'b0;
    smp(); chk("t4_dwait", 32'(dwait), 32'd0);
    cyc(); ram(FREE, 32'h0);
    smp(); chk("t4_bus_err", 32'(bus_err), 32'd1); chk("t4_ramren", 32'(ramREN), 32'd0);

    // RAM ERROR on a fetch returns the error word.
    cyc(); iREN = 1'b1; iaddr = 32'h44;
    smp();
    cyc(); ram(ERROR, 32'h1111); iq.push_back(ERRW); iREN = 1'b0;
    smp();
    cyc(); ram(FREE, 32'h0); cyc(); cyc();
    smp(); chk("t4_bus_err_sticky", 32'(bus_err), 32'd1);

    // Abort: fetch withdrawn mid-grant, strobe drops next cycle.
    cyc(); iREN = 1'b1; iaddr = 32'h48;
    smp();
    cyc(); ram(BUSY, 32'h0); iREN = 1'b0;
    smp(); chk("t5_abort_ramren", 32'(ramREN), 32'd1);
    cyc();
    smp(); chk("t5_abort_drop", 32'(ramREN), 32'd0); chk("t5_abort_idle", 32'(dut.state), S_IDLE);

    // Halt: only data is served.
    cyc(); halt = 1'b1; iREN = 1'b1; iaddr = 32'h500; dREN = 1'b1; daddr = 32'h600; ram(FREE, 32'h0);
    smp();
    cyc(); ram(ACCESS, 32'h77); dq.push_back(32'h77); dREN = 1'b0;
    smp(); chk("t6_state_d", 32'(dut.state), S_DGR); chk("t6_dstreak", 32'(dut.dstreak), 32'd0);
    cyc(); ram(FREE, 32'h0);
    smp(); chk("t6_idle", 32'(dut.state), S_IDLE); chk("t6_iwait", 32'(iwait), 32'd1);
    cyc();
    smp(); chk("t6_idle2", 32'(dut.state), S_IDLE); chk("t6_ramren", 32'(ramREN), 32'd0);
    cyc(); halt = 1'b0;
    smp();
    cyc(); ram(ACCESS, 32'h99); iq.push_back(32'h99); iREN = 1'b0;
    smp(); chk("t6_state_i", 32'(dut.state), S_IGR);
    cyc(); ram(FREE, 32'h0);

    // Reset pulse mid-DGRANT kills the write without an ack.
    cyc(); iREN = 1'b1; iaddr = 32'h800; dWEN = 1'b1; daddr = 32'h700; dstore = 32'h1;
    smp();
    cyc(); ram(BUSY, 32'h0);
    smp(); chk("t7_ramwen", 32'(ramWEN), 32'd1); chk("t7_dstreak1", 32'(dut.dstreak), 32'd1);
    cyc(); RST = 1'b1;
    smp(); chk("t7_rst_dwait", 32'(dwait), 32'd1);
    cyc(); RST = 1'b0;
    smp();
    chk("t7_state", 32'(dut.state), S_IDLE);
    chk("t7_ramwen0", 32'(ramWEN), 32'd0);
    chk("t7_ramren0", 32'(ramREN), 32'd0);
    chk("t7_dwait", 32'(dwait), 32'd1);
    chk("t7_dstreak0", 32'(dut.dstreak), 32'd0);
    chk("t7_bus_err0", 32'(bus_err), 32'd0);
    cyc(); ram(ACCESS, 32'h0); dq.push_back(32'h0); dWEN = 1'b0;
    smp();
    cyc(); ram(ACCESS, 32'h42); iq.push_back(32'h42); iREN = 1'b0;
    smp(); chk("t7_state_i", 32'(dut.state), S_IGR);
    cyc(); ram(FREE, 32'h0);
    smp(); chk("t7_idle", 32'(dut.state), S_IDLE);

    chk("iq_left", 32'(iq.size()), 32'd0);
    chk("dq_left", 32'(dq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
